// File: rtl/led_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : led_arbiter
// Purpose  : Round-robin arbiter that grants one of four requesters ownership
//            of a shared 8-bit LED drive for a minimum dwell time.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   DWELL        minimum grant duration in cycles (1 .. 2^24-1)
//   IDLE_PATTERN value driven on opLED while nobody holds the grant
// Ports
//   ipClk      in   1  system clock, rising edge
//   ipnReset   in   1  synchronous active-low reset
//   ipRequest  in   4  level-sensitive requests, bit i = requester i
//   ipData     in  32  LED values, [8i+7:8i] belongs to requester i
//   opGrant    out  4  registered one-hot (or zero) grant
//   opLED      out  8  registered LED drive
//   opBusy     out  1  OR of opGrant
// Configuration
//   LED_ARBITER_PREEMPT_EN  when defined, requester 0 preempts any other
//                           holder regardless of the dwell counter
// ============================================================================
module led_arbiter #(
  parameter int unsigned DWELL        = 4,
  parameter logic [7:0]  IDLE_PATTERN = 8'h00
) (
  input  logic        ipClk,
  input  logic        ipnReset,
  input  logic [3:0]  ipRequest,
  input  logic [31:0] ipData,
  output logic [3:0]  opGrant,
  output logic [7:0]  opLED,
  output logic        opBusy
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  localparam logic [23:0] c_dwellLoad = 24'(DWELL - 1);

  state_t      r_state, w_stateNext;
  logic [3:0]  r_grant, w_grantNext;
  logic [7:0]  r_led, w_ledNext;
  logic [1:0]  r_lastIdx, w_lastIdxNext;
  logic [23:0] r_dwell, w_dwellNext;
  logic [1:0]  w_rrWinner;
  logic        w_anyReq;

  // First requesting index searching upward (with wrap) from start.
  function automatic logic [1:0] rrPick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    rrPick = start;
    // Scan furthest offset first so the nearest requester overwrites last.
    for (int k = 3; k >= 0; k--) begin
      idx = start + k[1:0];
      if (req[idx]) rrPick = idx;
    end
  endfunction

  function automatic logic [7:0] ledSlice(input logic [31:0] data, input logic [1:0] idx);
    ledSlice = data[{idx, 3'b000} +: 8];
  endfunction

  assign w_anyReq = |ipRequest;
  // In IDLE the search starts after the last holder; in GRANTED the last
  // holder is the current holder, so the same start point serves both.
  assign w_rrWinner = rrPick(ipRequest, r_lastIdx + 2'd1);

`ifdef LED_ARBITER_PREEMPT_EN
  logic w_preempt;
  assign w_preempt = (r_state == GRANTED) && ipRequest[0] && (r_lastIdx != 2'd0);
`endif

  always_comb begin
    w_stateNext   = r_state;
    w_grantNext   = r_grant;
    w_ledNext     = r_led;
    w_lastIdxNext = r_lastIdx;
    w_dwellNext   = r_dwell;
    case (r_state)
      IDLE: begin
        w_grantNext = 4'b0000;
        w_ledNext   = IDLE_PATTERN;
        if (w_anyReq) begin
          w_stateNext   = GRANTED;
          w_grantNext   = 4'b0001 << w_rrWinner;
          w_lastIdxNext = w_rrWinner;
          w_dwellNext   = c_dwellLoad;
          w_ledNext     = ledSlice(ipData, w_rrWinner);
        end
      end
      GRANTED: begin
`ifdef LED_ARBITER_PREEMPT_EN
        if (w_preempt) begin
          w_grantNext   = 4'b0001;
          w_lastIdxNext = 2'd0;
          w_dwellNext   = c_dwellLoad;
          w_ledNext     = ledSlice(ipData, 2'd0);
        end else
`endif
        if (r_dwell != 24'd0) begin
          w_dwellNext = r_dwell - 24'd1;
          w_ledNext   = ledSlice(ipData, r_lastIdx);
        end else if (w_anyReq) begin
          // Winner may be the current holder when it is the only requester.
          w_grantNext   = 4'b0001 << w_rrWinner;
          w_lastIdxNext = w_rrWinner;
          w_dwellNext   = c_dwellLoad;
          w_ledNext     = ledSlice(ipData, w_rrWinner);
        end else begin
          // Last index is kept so fairness continues across idle periods.
          w_stateNext = IDLE;
          w_grantNext = 4'b0000;
          w_dwellNext = 24'd0;
          w_ledNext   = IDLE_PATTERN;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_grantNext = 4'b0000;
        w_dwellNext = 24'd0;
        w_ledNext   = IDLE_PATTERN;
      end
    endcase
  end

  always_ff @(posedge ipClk) begin
    if (!ipnReset) begin
      r_state   <= IDLE;
      r_grant   <= 4'b0000;
      r_led     <= IDLE_PATTERN;
      r_lastIdx <= 2'd3;
      r_dwell   <= 24'd0;
    end else begin
      r_state   <= w_stateNext;
      r_grant   <= w_grantNext;
      r_led     <= w_ledNext;
      r_lastIdx <= w_lastIdxNext;
      r_dwell   <= w_dwellNext;
    end
  end

  assign opGrant = r_grant;
  assign opLED   = r_led;
  assign opBusy  = |r_grant;

endmodule
`default_nettype wire

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 The block SHALL have parameter DWELL, default 4, giving the minimum grant duration in clock cycles (legal range 1 to 2^24-1).
REQ-002 The block SHALL have parameter IDLE_PATTERN, default 8'h00, giving the value driven on opLED when no requester holds the grant.
REQ-003 The block SHALL have port ipClk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port ipnReset, input, 1 bit, the reset; it is synchronous and active-low.
REQ-005 The block SHALL have port ipRequest, input, 4 bits, one level-sensitive request per source; bit i is requester i.
REQ-006 The block SHALL have port ipData, input, 32 bits, the LED values; bits [8i+7:8i] belong to requester i.
REQ-007 The block SHALL have port opGrant, output, 4 bits, a registered one-hot (or all-zero) grant vector.
REQ-008 The block SHALL have port opLED, output, 8 bits, the registered LED drive shared among requesters.
REQ-009 The block SHALL have port opBusy, output, 1 bit, high whenever opGrant is non-zero.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE (opGrant = 0) and GRANTED (opGrant one-hot).
REQ-011 In IDLE, if any ipRequest bit is high at a clock edge, then on that edge the block SHALL grant the first requesting index searching upward, with wrap-around, from (last granted index + 1) mod 4, and SHALL enter GRANTED.
REQ-012 On every grant, the dwell counter SHALL load DWELL-1, and SHALL decrement once per cycle while in GRANTED and non-zero.
REQ-013 While the dwell counter is non-zero, the grant SHALL NOT change, even if the granted requester deasserts its request.
REQ-014 On the edge where the dwell counter equals 0, the block SHALL re-arbitrate among current requests in round-robin order, starting from the current index + 1.
REQ-015 If the re-arbitration winner is the current holder (it is the only requester), the grant SHALL be kept and the dwell counter reloaded.
REQ-016 If the re-arbitration winner is another requester, the grant SHALL switch to it, with no idle cycle, and the dwell counter SHALL be reloaded.
REQ-017 If no requests are present at dwell expiry, the block SHALL return to IDLE and SHALL retain the last granted index.
REQ-018 With DWELL = 1, the grant SHALL be re-evaluated on every edge.
REQ-019 opLED SHALL equal, one cycle later, the ipData slice of the requester whose grant is in effect after that edge; in IDLE, opLED SHALL equal IDLE_PATTERN.
REQ-020 Grant latency SHALL be one cycle: a request sampled at edge k in IDLE SHALL produce opGrant and opBusy high after edge k.
REQ-021 opBusy SHALL be exactly the OR-reduction of the registered opGrant.

Reset
REQ-022 When ipnReset is low at a clock edge, the block SHALL force the state to IDLE, opGrant to 0, opBusy to 0, opLED to IDLE_PATTERN, and the dwell counter to 0.
REQ-023 Reset SHALL set the last-granted index to 3, so that requester 0 has first priority after reset.
REQ-024 Reset asserted mid-grant SHALL take effect on that same edge, overriding any re-arbitration.
REQ-025 Reset SHALL have no asynchronous path.

Configuration
REQ-026 When macro LED_ARBITER_PREEMPT_EN is defined, a high ipRequest[0] while requester 1, 2 or 3 holds the grant SHALL switch the grant to requester 0 on the next edge, regardless of the dwell counter, and SHALL reload the dwell counter.
REQ-027 When LED_ARBITER_PREEMPT_EN is defined, requester 0 SHALL NOT be preempted, and round-robin SHALL resume from index 1 after its grant ends.
REQ-028 When LED_ARBITER_PREEMPT_EN is undefined, requester 0 SHALL be treated identically to the other requesters, and no preemption logic SHALL be synthesised.

Verification (DWELL=4, IDLE_PATTERN=8'h00)
REQ-029 Scenario: reset, then ipRequest=4'b0100 with ipData[23:16]=8'hA5 -> one cycle later opGrant=4'b0100, opBusy=1, opLED=8'hA5.
REQ-030 Scenario: ipRequest=4'b1111 held constant -> grants rotate 0,1,2,3,0, each held exactly 4 cycles, with no gap cycles.
REQ-031 Scenario: requester 2 granted, then drops its request after 1 cycle with no other requests -> grant holds 4 cycles total, then opGrant=0 and opLED=8'h00.
REQ-032 Scenario: ipnReset driven low for one edge during the 2nd cycle of a grant to requester 3 -> next cycle opGrant=0; with ipRequest=4'b1001 afterwards, requester 0 wins first.
REQ-033 Scenario: with LED_ARBITER_PREEMPT_EN defined, requester 1 granted and ipRequest[0] rises in dwell cycle 2 -> opGrant=4'b0001 on the next edge, held 4 cycles; without the macro -> requester 1 keeps the grant for its full 4 cycles.
